// File: rtl/dmem_arbiter.sv
// Round-robin, burst-limited arbiter for the shared data-memory port.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_wr,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_ack,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_wr,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic             m1_ack,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,
    output logic             dm_rd,
    output logic             dm_wr,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata,
    input  logic             dm_accessable,
    output logic [CNT_W-1:0] m0_grant_cnt,
    output logic [CNT_W-1:0] m1_grant_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BLIM = BW'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;

    logic [1:0]    r_state;
    logic          r_last;
    logic [BW-1:0] r_burst;

    logic [1:0]    w_nstate;
    logic          w_nlast;
    logic [BW-1:0] w_nburst;
    logic          w_own;
    logic          w_oth;
    logic          w_g0;
    logic          w_g1;

    // r_last = 1 means master 1 was granted most recently
    assign w_own = (r_state == S_GNT1) ? m1_req : m0_req;
    assign w_oth = (r_state == S_GNT1) ? m0_req : m1_req;

    always_comb begin
        w_nstate = r_state;
        w_nlast  = r_last;
        w_nburst = r_burst;
        case (r_state)
            S_GNT0, S_GNT1: begin
                w_nlast  = (r_state == S_GNT1);
                w_nburst = '0;
                if (w_own && w_oth && (r_burst < BLIM)) begin
                    w_nburst = r_burst + 1'b1;
                end else if (w_oth) begin
                    w_nstate = (r_state == S_GNT1) ? S_GNT0 : S_GNT1;
                end else if (!w_own) begin
                    w_nstate = S_IDLE;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                if (m0_req && m1_req) begin
                    w_nstate = r_last ? S_GNT0 : S_GNT1;
                end else if (m0_req) begin
                    w_nstate = S_GNT0;
                end else if (m1_req) begin
                    w_nstate = S_GNT1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_burst <= '0;
        end else begin
            r_state <= w_nstate;
            r_last  <= w_nlast;
            r_burst <= w_nburst;
        end
    end

    // A grant only performs an access while its owner is still requesting
    assign w_g0 = ~reset & (r_state == S_GNT0) & m0_req;
    assign w_g1 = ~reset & (r_state == S_GNT1) & m1_req;

    assign dm_rd    = (w_g0 & ~m0_wr) | (w_g1 & ~m1_wr);
    assign dm_wr    = (w_g0 & m0_wr) | (w_g1 & m1_wr);
    assign dm_addr  = w_g0 ? m0_addr : (w_g1 ? m1_addr : '0);
    assign dm_wdata = w_g0 ? m0_wdata : (w_g1 ? m1_wdata : '0);

    assign m0_ack   = w_g0;
    assign m0_rdata = w_g0 ? dm_rdata : '0;
    assign m0_err   = w_g0 & ~dm_accessable;
    assign m1_ack   = w_g1;
    assign m1_rdata = w_g1 ? dm_rdata : '0;
    assign m1_err   = w_g1 & ~dm_accessable;

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] r_g0_cnt;
    logic [CNT_W-1:0] r_g1_cnt;
    logic [CNT_W-1:0] r_cf_cnt;
    logic             w_conf;

    assign w_conf = (w_g0 & m1_req) | (w_g1 & m0_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_g0_cnt <= '0;
            r_g1_cnt <= '0;
            r_cf_cnt <= '0;
        end else begin
            if (w_g0 && (r_g0_cnt != '1)) r_g0_cnt <= r_g0_cnt + 1'b1;
            if (w_g1 && (r_g1_cnt != '1)) r_g1_cnt <= r_g1_cnt + 1'b1;
            if (w_conf && (r_cf_cnt != '1)) r_cf_cnt <= r_cf_cnt + 1'b1;
        end
    end

    assign m0_grant_cnt = r_g0_cnt;
    assign m1_grant_cnt = r_g1_cnt;
    assign conflict_cnt = r_cf_cnt;
`else
    assign m0_grant_cnt = '0;
    assign m1_grant_cnt = '0;
    assign conflict_cnt = '0;
`endif

endmodule
